cpu_run_ctrl: RTL



---
 rtl/cpu_run_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt controller owning the mips reset and clock enable
module cpu_run_ctrl #(
    parameter int RESET_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_code,
    input  logic [15:0]          step_count,
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
    input  logic [31:0]          cpu_pc,
    input  logic                 cpu_halt_req,
    output logic                 cpu_reset,
    output logic                 cpu_clk_en,
    output logic                 cmd_ready,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 bp_hit
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_t                 st, st_n;
    logic [RC_W-1:0]        rst_cnt, rst_cnt_n;
    logic [15:0]            remaining, remaining_n;
    logic                   skip_bp, skip_bp_n;
    logic                   bp_hit_n;
    logic                   clear_count;
    logic [CNT_WIDTH-1:0]   cycle_count_n;

    logic acc, acc_run, acc_halt, acc_step, acc_reset;
    logic bp_match, stop, active;

    assign acc       = cmd_valid && cmd_ready;
    assign acc_run   = acc && (cmd_code == 3'd1);
    assign acc_halt  = acc && (cmd_code == 3'd2);
    assign acc_step  = acc && (cmd_code == 3'd3);
    assign acc_reset = acc && (cmd_code == 3'd4);

    // skip_bp lets the instruction sitting on the breakpoint execute once on resume
    assign bp_match = bp_en && (cpu_pc == bp_addr) && !skip_bp;
    assign stop     = bp_match || cpu_halt_req || acc_halt;
    assign active   = (st == ST_RUN) || (st == ST_STEP);

    assign cpu_clk_en = active && !stop && !acc_reset && !Reset;
    assign state      = st;

    always_comb begin
        st_n        = st;
        rst_cnt_n   = rst_cnt;
        remaining_n = remaining;
        skip_bp_n   = skip_bp;
        bp_hit_n    = bp_hit;
        clear_count = 1'b0;
        case (st)
            ST_RST: begin
                if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    st_n      = ST_HALTED;
                    rst_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            ST_HALTED: begin
                if (acc_run || acc_step || acc_reset) begin
                    bp_hit_n  = 1'b0;
                    skip_bp_n = 1'b1;
                end
                if (acc_run) begin
                    st_n = ST_RUN;
                end else if (acc_step) begin
                    st_n        = ST_STEP;
                    remaining_n = (step_count == 16'd0) ? 16'd1 : step_count;
                end else if (acc_reset) begin
                    st_n        = ST_RST;
                    rst_cnt_n   = '0;
                    clear_count = 1'b1;
                end
            end
            default: begin
                skip_bp_n = 1'b0;
                if (acc_reset) begin
                    st_n        = ST_RST;
                    rst_cnt_n   = '0;
                    clear_count = 1'b1;
                end else if (stop) begin
                    st_n     = ST_HALTED;
                    bp_hit_n = bp_match;
                end else if (st == ST_STEP) begin
                    remaining_n = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        st_n = ST_HALTED;
                    end
                end
            end
        endcase

        cycle_count_n = cycle_count;
        if (clear_count) begin
            cycle_count_n = '0;
        end else if (cpu_clk_en && (cycle_count != {CNT_WIDTH{1'b1}})) begin
            cycle_count_n = cycle_count + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            st          <= ST_RST;
            rst_cnt     <= '0;
            remaining   <= '0;
            skip_bp     <= 1'b0;
            bp_hit      <= 1'b0;
            cycle_count <= '0;
            cpu_reset   <= 1'b1;
            cmd_ready   <= 1'b0;
        end else begin
            st          <= st_n;
            rst_cnt     <= rst_cnt_n;
            remaining   <= remaining_n;
            skip_bp     <= skip_bp_n;
            bp_hit      <= bp_hit_n;
            cycle_count <= cycle_count_n;
            cpu_reset   <= (st_n == ST_RST);
            cmd_ready   <= (st_n != ST_RST);
        end
    end

endmodule
